// File: rtl/spi_slave_fifo.sv
// SPI slave on sclk: mosi deserialised into dout (valid on the final-bit edge), miso fed from a TX FIFO.
// No backpressure toward the master: an empty FIFO sends IDLE_PATTERN, and a write to a full FIFO is dropped.
module spi_slave_fifo #(
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    TX_DEPTH     = 4,
   parameter bit                    MSB_FIRST    = 1'b1,
   parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '1
) (
   input  logic                          sclk,
   input  logic                          i_reset,
   input  logic                          cs,
   input  logic                          mosi,
   output logic                          miso,
   output logic [DATA_WIDTH-1:0]         dout,
   output logic                          dout_valid,
   input  logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_wr,
   output logic                          tx_full,
   output logic                          tx_empty,
   output logic [$clog2(TX_DEPTH+1)-1:0] tx_count,
   output logic                          tx_underrun,
   output logic                          tx_overflow,
   output logic                          frame_err
);

   localparam int AW = $clog2(TX_DEPTH);
   localparam int CW = $clog2(TX_DEPTH+1);
   localparam int BW = $clog2(DATA_WIDTH);

   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;
   logic                  miso_q, miso_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  underrun_q, underrun_d;
   logic                  overflow_q, overflow_d;
   logic                  frame_err_q, frame_err_d;
   logic [DATA_WIDTH-1:0] mem_q [TX_DEPTH];

   logic                  word_start, pop, push;
   logic [DATA_WIDTH-1:0] rx_next, tx_next;

   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      rx_sh_d      = rx_sh_q;
      tx_sh_d      = tx_sh_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      miso_d       = miso_q;
      underrun_d   = 1'b0;
      frame_err_d  = 1'b0;
      rx_next      = rx_sh_q;
      tx_next      = tx_sh_q;

      word_start = !cs && (bit_cnt_q == '0);
      pop        = word_start && (count_q != '0);
      // A full FIFO still accepts a write when the same edge pops the head.
      push       = tx_wr && ((count_q != CW'(TX_DEPTH)) || pop);
      overflow_d = tx_wr && !push;

      if (cs) begin
         bit_cnt_d   = '0;
         miso_d      = 1'b0;
         rx_sh_d     = '0;
         frame_err_d = (bit_cnt_q != '0);
      end else begin
         bit_cnt_d = (bit_cnt_q == BW'(DATA_WIDTH-1)) ? '0 : bit_cnt_q + BW'(1);
         if (MSB_FIRST) rx_next = {rx_sh_q[DATA_WIDTH-2:0], mosi};
         else           rx_next = {mosi, rx_sh_q[DATA_WIDTH-1:1]};
         rx_sh_d = rx_next;
         if (bit_cnt_q == BW'(DATA_WIDTH-1)) begin
            dout_d       = rx_next;
            dout_valid_d = 1'b1;
         end
         if (word_start) begin
            tx_next    = pop ? mem_q[rd_ptr_q] : IDLE_PATTERN;
            underrun_d = !pop;
         end else if (MSB_FIRST) begin
            tx_next = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
         end else begin
            tx_next = {1'b0, tx_sh_q[DATA_WIDTH-1:1]};
         end
         tx_sh_d = tx_next;
         miso_d  = MSB_FIRST ? tx_next[DATA_WIDTH-1] : tx_next[0];
      end

      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(TX_DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge sclk) begin
      if (i_reset) begin
         bit_cnt_q    <= '0;
         rx_sh_q      <= '0;
         tx_sh_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         miso_q       <= 1'b0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         underrun_q   <= 1'b0;
         overflow_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         rx_sh_q      <= rx_sh_d;
         tx_sh_q      <= tx_sh_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         miso_q       <= miso_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         underrun_q   <= underrun_d;
         overflow_q   <= overflow_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_ff @(posedge sclk) begin
      if (!i_reset && push) mem_q[wr_ptr_q] <= tx_data;
   end

   assign miso        = miso_q;
   assign dout        = dout_q;
   assign dout_valid  = dout_valid_q;
   assign tx_full     = full_q;
   assign tx_empty    = empty_q;
   assign tx_count    = count_q;
   assign tx_underrun = underrun_q;
   assign tx_overflow = overflow_q;
   assign frame_err   = frame_err_q;

endmodule
